add8_sched: RTL and testbench

ADD8_SCHED -- requirements
Module: add8_sched

---
 rtl/add8_sched.sv | 112 +++++++++++
 tb/tb_add8_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add8_sched.sv
// add8_sched: round-robin scheduler feeding one shared 8-bit adder, two-stage pipe.
// Optional exact-sum error report enabled by `define ADD8_SCHED_EXACT_CHK_EN.
module add8_sched #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        add_a,
    output logic [7:0]        add_b,
    input  logic [8:0]        add_o,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_id,
    output logic [8:0]        rsp_sum,
    output logic [3:0]        rsp_err,
    output logic [CNT_W-1:0]  txn_cnt
);

    logic       s1_valid;
    logic [1:0] s1_id;
    logic [1:0] ptr;
    logic       adv;
    logic       ld1;
    logic       gnt_hit;
    logic [1:0] gnt_id;
    logic [1:0] idx;
    logic [3:0] err_nxt;

    assign adv = !rsp_valid || rsp_ready;
    assign ld1 = !s1_valid || adv;

    // Round-robin search upward from ptr, wrapping 3 -> 0
    always_comb begin
        gnt_hit = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!gnt_hit && req_valid[idx]) begin
                gnt_hit = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    // Grant is one-hot, suppressed while S1 cannot load or reset is held
    always_comb begin
        req_ready = '0;
        if (rst_n && ld1 && gnt_hit)
            req_ready = 4'b0001 << gnt_id;
    end

`ifdef ADD8_SCHED_EXACT_CHK_EN
    logic [8:0] exact;
    logic [8:0] diff;
    assign exact   = {1'b0, add_a} + {1'b0, add_b};
    assign diff    = (exact >= add_o) ? (exact - add_o) : (add_o - exact);
    assign err_nxt = (diff > 9'd15) ? 4'hf : diff[3:0];
`else
    assign err_nxt = 4'h0;
`endif

    // S1 issue stage: capture granted operands and advance the pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            ptr      <= '0;
            add_a    <= '0;
            add_b    <= '0;
        end else if (ld1) begin
            s1_valid <= gnt_hit;
            if (gnt_hit) begin
                s1_id <= gnt_id;
                ptr   <= gnt_id + 2'd1;
                add_a <= req_a[{gnt_id, 3'b000} +: 8];
                add_b <= req_b[{gnt_id, 3'b000} +: 8];
            end
        end
    end

    // S2 output stage: latch the adder result when downstream can take it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_err   <= '0;
        end else if (adv) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_id  <= s1_id;
                rsp_sum <= add_o;
                rsp_err <= err_nxt;
            end
        end
    end

    // Delivered-response counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            txn_cnt <= '0;
        else if (rsp_valid && rsp_ready)
            txn_cnt <= txn_cnt + 1'b1;
    end

endmodule

// File: tb/tb_add8_sched.sv
// tb_add8_sched: randomized scoreboard bench for add8_sched.
// Reference is a 2-deep in-order queue with minimum latency 2 and RR arbitration.
module tb_add8_sched;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    req_valid = 4'hf;
    logic [31:0]   req_a = '0;
    logic [31:0]   req_b = '0;
    logic [3:0]    req_ready;
    logic [7:0]    add_a, add_b;
    logic [8:0]    add_o;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_id;
    logic [8:0]    rsp_sum;
    logic [3:0]    rsp_err;
    logic [CW-1:0] txn_cnt;

    int n_chk = 0;
    int n_err = 0;
    int mode  = 0;

    typedef struct {
        logic [1:0] id;
        logic [8:0] sum;
        logic [3:0] err;
    } exp_t;

    exp_t sb[$];
    int   m_q[$];
    int   m_ptr = 0;
    int   m_cnt = 0;
    int   cyc   = 0;

    add8_sched #(.NREQ(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_o(add_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
        .txn_cnt(txn_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] approx(logic [7:0] a, logic [7:0] b, int md);
        logic [8:0] e;
        e = {1'b0, a} + {1'b0, b};
        case (md)
            1: return e - 9'd7;
            2: return e & 9'h1fe;
            3: return e ^ 9'h010;
            default: return e;
        endcase
    endfunction

    function automatic logic [3:0] exp_err(logic [7:0] a, logic [7:0] b, logic [8:0] ap);
`ifdef ADD8_SCHED_EXACT_CHK_EN
        int ex;
        int d;
        ex = int'(a) + int'(b);
        d  = ex - int'(ap);
        if (d < 0) d = -d;
        return (d > 15) ? 4'd15 : 4'(d);
`else
        return 4'd0;
`endif
    endfunction

    // shared comparator; also used by the monitor
    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // adder model driven combinationally from the DUT operands
    always_comb add_o = approx(add_a, add_b, mode);

    // one clock of stimulus plus reference-model update
    task automatic step(input logic [3:0] v, input logic [31:0] a,
                        input logic [31:0] b, input logic rr);
        logic    vis, dlv, acc;
        int      g;
        logic [3:0] er;
        logic [7:0] ga, gb;
        exp_t    e;
        @(negedge clk);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        #1;
        vis = (m_q.size() > 0) && (m_q[0] <= cyc - 2);
        dlv = vis && rr;
        acc = (m_q.size() < 2) || dlv;
        g = -1;
        if (acc)
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr + k) % 4;
                if (g < 0 && v[j]) g = j;
            end
        er = (g >= 0) ? 4'(1 << g) : 4'd0;
        check("req_ready", req_ready, er);
        check("rsp_valid", rsp_valid, vis);
        check("txn_cnt", txn_cnt, m_cnt % (1 << CW));
        @(posedge clk);
        if (dlv) begin
            void'(m_q.pop_front());
            m_cnt++;
        end
        if (g >= 0) begin
            ga    = a[8*g +: 8];
            gb    = b[8*g +: 8];
            e.id  = 2'(g);
            e.sum = approx(ga, gb, mode);
            e.err = exp_err(ga, gb, e.sum);
            sb.push_back(e);
            m_q.push_back(cyc);
            m_ptr = (g + 1) % 4;
        end
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(4'h0, '0, '0, 1'b1);
    endtask

    // monitor: compare presented response with scoreboard head, pop on accept
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && rsp_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL rsp_unexpected id=%0d sum=%h t=%0t",
                             rsp_id, rsp_sum, $time);
                end else begin
                    check("rsp_id", rsp_id, sb[0].id);
                    check("rsp_sum", rsp_sum, sb[0].sum);
                    check("rsp_err", rsp_err, sb[0].err);
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    task automatic chk_reset_outs();
        check("rst_req_ready", req_ready, 4'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_add_a", add_a, 8'h0);
        check("rst_add_b", add_b, 8'h0);
        check("rst_rsp_id", rsp_id, 2'h0);
        check("rst_rsp_sum", rsp_sum, 9'h0);
        check("rst_rsp_err", rsp_err, 4'h0);
        check("rst_txn_cnt", txn_cnt, '0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        #3;
        chk_reset_outs();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // single request from requester 2
        mode = 0;
        step(4'b0100, 32'h003c_0000, 32'h0015_0000, 1'b1);
        drain();

        // fairness: all valid, free-flowing
        for (int i = 0; i < 9; i++)
            step(4'hf, $urandom, $urandom, 1'b1);
        drain();

        // backpressure: 5 stalled cycles, then release
        for (int i = 0; i < 5; i++)
            step(4'hf, $urandom, $urandom, 1'b0);
        step(4'h0, '0, '0, 1'b1);
        drain();

        // approximate adder: exact-7 on 0xFF+0x01
        mode = 1;
        step(4'b0001, 32'h0000_00ff, 32'h0000_0001, 1'b1);
        step(4'b1000, 32'hff00_0000, 32'h0100_0000, 1'b1);
        drain();

        // randomized traffic across adder models
        for (int md = 0; md < 4; md++) begin
            mode = md;
            for (int i = 0; i < 120; i++) begin
                ra = $urandom;
                rb = $urandom;
                step(4'($urandom_range(0, 15)), ra, rb,
                     ($urandom_range(0, 3) != 0));
            end
            drain();
        end

        // reset with S1 and S2 full
        mode = 0;
        for (int i = 0; i < 3; i++)
            step(4'hf, $urandom, $urandom, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outs();
        sb.delete();
        m_q.delete();
        m_ptr = 0;
        m_cnt = 0;
        @(posedge clk);
        #3;
        check("rst_hold_rsp_valid", rsp_valid, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++)
            step(4'hf, $urandom, $urandom, 1'b1);
        drain();
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
